// File: rtl/keypad_scan4.sv
// 4x4 active-low matrix keypad scanner with press/release debounce, hex encoding
// and a sticky key register acknowledged by the CPU through KeyCtrl.
module keypad_scan4 #(
    parameter int SCAN_DIV     = 2000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    input  logic       KeyCtrl,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       overrun
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [3:0]    col_meta_r, col_sync_r;
    logic [1:0]    idx_r, idx_s;
    logic [DW-1:0] dwell_r, dwell_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    cap_col_r, cap_col_s;
    logic [3:0]    key_code_s;
    logic          key_valid_s, key_held_s, overrun_s;
    logic          accept_s;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        logic [1:0] pos;
        if (!c[0])      pos = 2'd0;
        else if (!c[1]) pos = 2'd1;
        else if (!c[2]) pos = 2'd2;
        else            pos = 2'd3;
        return pos;
    endfunction

    // Two-flop column synchronizer; resets to the idle (released) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_r <= 4'hF;
            col_sync_r <= 4'hF;
        end else begin
            col_meta_r <= col;
            col_sync_r <= col_meta_r;
        end
    end

    // Next-state and output logic; idx stays frozen outside SCAN, so it doubles as the captured row.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        dwell_s     = dwell_r;
        cnt_s       = cnt_r;
        cap_col_s   = cap_col_r;
        key_code_s  = key_code;
        key_held_s  = key_held;
        accept_s    = 1'b0;
        case (state_r)
            SCAN: begin
                if (dwell_r == DWELL_LAST) begin
                    dwell_s = {DW{1'b0}};
                    if (col_sync_r == 4'hF) begin
                        idx_s = idx_r + 2'd1;
                    end else begin
                        cap_col_s = lowest_low(col_sync_r);
                        cnt_s     = {CW{1'b0}};
                        state_s   = DEBOUNCE;
                    end
                end else begin
                    dwell_s = dwell_r + {{(DW-1){1'b0}}, 1'b1};
                end
            end
            DEBOUNCE: begin
                if (!col_sync_r[cap_col_r]) begin
                    if (cnt_r == DEB_LAST) begin
                        cnt_s      = {CW{1'b0}};
                        state_s    = PRESSED;
                        accept_s   = 1'b1;
                        key_code_s = key_map(idx_r, cap_col_r);
                        key_held_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_s   = {CW{1'b0}};
                    dwell_s = {DW{1'b0}};
                    idx_s   = idx_r + 2'd1;
                    state_s = SCAN;
                end
            end
            PRESSED: begin
                if (col_sync_r[cap_col_r]) begin
                    if (cnt_r == DEB_LAST) begin
                        cnt_s      = {CW{1'b0}};
                        dwell_s    = {DW{1'b0}};
                        idx_s      = idx_r + 2'd1;
                        key_held_s = 1'b0;
                        state_s    = SCAN;
                    end else begin
                        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_s = {CW{1'b0}};
                end
            end
            default: begin
                state_s = SCAN;
                cnt_s   = {CW{1'b0}};
                dwell_s = {DW{1'b0}};
            end
        endcase

        // A press accepted on the acknowledge edge wins over the acknowledge.
        if (accept_s) begin
            key_valid_s = 1'b1;
            overrun_s   = KeyCtrl ? 1'b0 : (overrun | key_valid);
        end else if (KeyCtrl) begin
            key_valid_s = 1'b0;
            overrun_s   = 1'b0;
        end else begin
            key_valid_s = key_valid;
            overrun_s   = overrun;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= SCAN;
            idx_r     <= 2'd0;
            dwell_r   <= {DW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            cap_col_r <= 2'd0;
            row       <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            dwell_r   <= dwell_s;
            cnt_r     <= cnt_s;
            cap_col_r <= cap_col_s;
            row       <= ~(4'b0001 << idx_s);
            key_code  <= key_code_s;
            key_valid <= key_valid_s;
            key_held  <= key_held_s;
            overrun   <= overrun_s;
        end
    end

endmodule

// File: doc/keypad_scan4.md
Name: keypad_scan4

Overview:
- 4x4 matrix keypad scanner: the input-side counterpart of the 4-digit seven-segment display scanner.
- Drives one active-low row at a time and reads active-low columns. Debounces press and release, encodes the key into a 4-bit hex value, and holds it in a register.
- The CPU MMIO read path consumes the held value and acknowledges it with a one-cycle KeyCtrl strobe, the same style as LEDCtrl on the display side.

Parameters:
SCAN_DIV, 2000, clk cycles each row is held low before its columns are sampled (minimum 2)
DEBOUNCE_CNT, 20000, consecutive stable cycles required to accept a press or a release (minimum 1)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
col  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk
KeyCtrl  input  1  CPU read acknowledge; sampled on the clk edge; clears key_valid and overrun
row  output  4  keypad rows, active-low, exactly one bit low at all times
key_code  output  4  hex code of the last accepted key
key_valid  output  1  sticky: a new key is available and not yet acknowledged
key_held  output  1  an accepted key is currently still pressed
overrun  output  1  sticky: a key was accepted while key_valid was already 1

Behaviour:
- Reset (async, rst=1) forces the following state:
  - row=4'b1110 (scan index 0)
  - key_code=0, key_valid=0, key_held=0, overrun=0
  - state=SCAN; dwell, debounce and synchronizer registers cleared
  - Reset asserted mid-press abandons the press; a held key must then be released and re-pressed after rst falls.
- col passes through a 2-flop synchronizer (col_s). All decisions in this section use col_s.
- row = ~(4'b0001 << idx). idx is a 2-bit scan index that wraps 3->0.
- Key map, idx,col-bit -> code:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E,0,F,D
- State SCAN:
  - The dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle: if col_s==4'hF, idx increments and the dwell counter clears.
  - Otherwise the lowest-numbered low column is captured (cap_idx=idx, cap_col), the debounce counter clears, and the state goes to DEBOUNCE. idx does not advance.
- State DEBOUNCE:
  - row stays frozen on cap_idx.
  - Each cycle with col_s[cap_col]==0 increments the counter. When the counter reaches DEBOUNCE_CNT, the state goes to PRESSED.
  - Any cycle with col_s[cap_col]==1: return to SCAN with the counter cleared and the dwell cleared. idx advances to the next row.
- Entry to PRESSED, same edge as the transition:
  - key_code <= map(cap_idx,cap_col); key_held <= 1; key_valid <= 1
  - If key_valid was already 1, overrun <= 1.
- State PRESSED:
  - row stays frozen.
  - The counter counts consecutive cycles with col_s[cap_col]==1; any 0 clears it.
  - At DEBOUNCE_CNT: key_held <= 0, go to SCAN, idx advances.
  - Other keys pressed meanwhile are ignored. Only one key is reported per press.
- KeyCtrl=1 on an edge clears key_valid and overrun.
  - If a press is accepted on the same edge, the new key wins: key_valid=1, key_code=new, overrun=0.
- key_code changes only on press acceptance. It holds through release and acknowledge.
- Press latency, measured from a clean, stable column low: up to 4*SCAN_DIV cycles to reach the row, plus 2 cycles of synchronizer, plus DEBOUNCE_CNT cycles.
- Bounce shorter than DEBOUNCE_CNT never produces key_valid. Release bounce never produces a second key.

Test Plan:
- Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=8.
- Reset, no keys -> row cycles 1110,1101,1011,0111 every 4 clocks; all outputs 0. Assert rst mid-dwell -> row=1110 immediately, without waiting for a clk edge.
- Hold row2/col1 low solidly -> row freezes at 1011; key_code=4'h8, key_valid=1, key_held=1 within 16+2+8 cycles. Release -> key_held=0 after 8 stable-high cycles; scan resumes at 0111.
- Press row0/col3 with 3-cycle pulses separated by gaps -> key_valid stays 0 and scanning continues. Then hold solidly -> key_code=4'hA.
- Accept key 5, then press and release key 0 without KeyCtrl -> key_code=4'h0, overrun=1. Pulse KeyCtrl -> key_valid=0, overrun=0, key_code remains 4'h0.
- KeyCtrl pulse coincident with acceptance of key D -> key_valid=1, key_code=4'hD, overrun=0.
- Hold key 4 (row1/col0) and press key 6 during PRESSED -> only 4'h4 is reported. Release both -> no further key_valid.
